// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serialises bitstream words into ccff_head, gates
// prog_clk through prog_clk_en, and returns the displaced chain contents as readback words.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              prog_clk_en,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    input  logic              rb_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int BL_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [BL_W-1:0]  FULL_WORD = BL_W'(WORD_W);
    localparam logic [BL_W-1:0]  RB_LAST   = BL_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [WORD_W-1:0] sreg;
    logic [BL_W-1:0]   bits_left;
    logic [WORD_W-1:0] rb_buf;
    logic [WORD_W-1:0] rb_buf_cap;
    logic [BL_W-1:0]   rb_cnt;

    logic shift;
    logic accept;
    logic final_shift;
    logic rb_take;
    logic rb_word_full;
    logic launch;

    always_comb begin
        shift        = (state == S_LOAD) && (bits_left != '0) && !(rb_valid && !rb_ready);
        // Ready is offered while the last bit of the current word is leaving, so words stream without a bubble.
        cfg_ready    = (state == S_LOAD) &&
                       ((bits_left == '0) || ((bits_left == BL_W'(1)) && shift));
        accept       = cfg_valid && cfg_ready;
        final_shift  = shift && (bit_count == LAST_BIT);
        rb_take      = rb_valid && rb_ready;
        rb_word_full = (rb_cnt == RB_LAST);
        launch       = start && ((state == S_IDLE) || (state == S_DONE));
        prog_clk_en  = shift;
        ccff_head    = (bits_left != '0) ? sreg[0] : 1'b0;
        busy         = (state == S_LOAD) || (state == S_DRAIN);
        done         = (state == S_DONE);
    end

    always_comb begin
        rb_buf_cap = rb_buf;
        for (int unsigned i = 0; i < WORD_W; i++) begin
            if (rb_cnt == BL_W'(i)) begin
                rb_buf_cap[i] = ccff_tail;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_LOAD;
            S_LOAD:  if (final_shift) state_nx = S_DRAIN;
            S_DRAIN: if (rb_take) state_nx = S_DONE;
            S_DONE:  if (start) state_nx = S_LOAD;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            sreg      <= '0;
            bits_left <= '0;
            bit_count <= '0;
            rb_buf    <= '0;
            rb_cnt    <= '0;
            rb_data   <= '0;
            rb_valid  <= 1'b0;
        end else if (launch) begin
            sreg      <= '0;
            bits_left <= '0;
            bit_count <= '0;
            rb_buf    <= '0;
            rb_cnt    <= '0;
            rb_data   <= '0;
            rb_valid  <= 1'b0;
        end else begin
            if (rb_take) begin
                rb_valid <= 1'b0;
            end
            if (shift) begin
                sreg      <= sreg >> 1;
                bits_left <= bits_left - BL_W'(1);
                bit_count <= bit_count + CNT_W'(1);
                if (rb_word_full || final_shift) begin
                    rb_data  <= rb_buf_cap;
                    rb_valid <= 1'b1;
                    rb_buf   <= '0;
                    rb_cnt   <= '0;
                end else begin
                    rb_buf <= rb_buf_cap;
                    rb_cnt <= rb_cnt + BL_W'(1);
                end
            end
            // Later assignments win: a new word replaces the drained one, and completion discards any remainder.
            if (accept) begin
                sreg      <= cfg_data;
                bits_left <= FULL_WORD;
            end
            if (final_shift) begin
                bits_left <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: a behavioural fabric chain supplies ccff_tail,
// expected head bits and readback words are queued per load and checked by a monitor.
module tb_ccff_chain_loader;

    localparam int CL  = 10;
    localparam int WW  = 4;
    localparam int CW  = $clog2(CL + 1);
    localparam int NW  = 3;
    localparam int NRB = 3;

    logic          prog_clk;
    logic          pReset_n;
    logic          start;
    logic [WW-1:0] cfg_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          ccff_head;
    logic          ccff_tail;
    logic          prog_clk_en;
    logic [WW-1:0] rb_data;
    logic          rb_valid;
    logic          rb_ready;
    logic          busy;
    logic          done;
    logic [CW-1:0] bit_count;

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk    (prog_clk),
        .pReset_n    (pReset_n),
        .start       (start),
        .cfg_data    (cfg_data),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .ccff_head   (ccff_head),
        .ccff_tail   (ccff_tail),
        .prog_clk_en (prog_clk_en),
        .rb_data     (rb_data),
        .rb_valid    (rb_valid),
        .rb_ready    (rb_ready),
        .busy        (busy),
        .done        (done),
        .bit_count   (bit_count)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Fabric model: a plain shift register clocked by the gated prog_clk.
    logic [CL-1:0] chain = '0;
    logic [CL-1:0] preload_val = '0;
    logic          preload_req = 1'b0;
    logic          en_s = 1'b0;
    logic          head_s = 1'b0;

    always @(posedge prog_clk) begin
        if (preload_req) chain <= preload_val;
        else if (en_s && pReset_n) chain <= {chain[CL-2:0], head_s};
    end
    assign ccff_tail = chain[CL-1];

    // Scoreboard queues and monitor
    logic          head_q[$];
    logic [WW-1:0] rb_q[$];
    logic          head_log[$];
    logic [WW-1:0] rb_log[$];
    logic          mon_on = 1'b0;
    int            load_id = 0;
    int            seen_id = 0;
    int            cyc = 0;
    int            nshift = 0;
    int            first_cyc = 0;
    int            last_cyc = 0;
    logic          prev_hold = 1'b0;
    logic [WW-1:0] prev_rb = '0;

    always @(negedge prog_clk) begin
        logic          eh;
        logic [WW-1:0] er;
        cyc++;
        en_s   = prog_clk_en;
        head_s = ccff_head;
        if (load_id != seen_id) begin
            seen_id = load_id;
            nshift = 0; first_cyc = 0; last_cyc = 0;
            head_log.delete();
            rb_log.delete();
        end
        if (pReset_n && mon_on) begin
            if (prog_clk_en) begin
                if (head_q.size() == 0) chk("extra_shift", 32'd1, 32'd0);
                else begin
                    eh = head_q.pop_front();
                    chk("ccff_head", 32'(ccff_head), 32'(eh));
                end
                head_log.push_back(ccff_head);
                if (nshift == 0) first_cyc = cyc;
                last_cyc = cyc;
                nshift++;
            end
            if (rb_valid && rb_ready) begin
                if (rb_q.size() == 0) chk("extra_rb_word", 32'd1, 32'd0);
                else begin
                    er = rb_q.pop_front();
                    chk("rb_data", 32'(rb_data), 32'(er));
                end
                rb_log.push_back(rb_data);
            end
            if (rb_valid && !rb_ready) begin
                chk("stall_en", 32'(prog_clk_en), 32'd0);
                if (prev_hold) chk("rb_stable", 32'(rb_data), 32'(prev_rb));
            end
        end
        prev_hold = rb_valid && !rb_ready;
        prev_rb   = rb_data;
    end

    logic load_over = 1'b0;
    logic prev_done = 1'b0;

    task automatic cfg_drive(input logic [WW-1:0] w [NW], input int g [NW]);
        int n, t;
        logic acc;
        @(posedge prog_clk); #1;
        for (int i = 0; i < NW; i++) begin
            cfg_valid = 1'b0;
            n = 0; t = 0;
            while (n < g[i] && t < 200) begin
                @(negedge prog_clk);
                if (cfg_ready) n++;
                t++;
                @(posedge prog_clk); #1;
            end
            cfg_data  = w[i];
            cfg_valid = 1'b1;
            acc = 1'b0; t = 0;
            while (!acc && t < 200) begin
                @(negedge prog_clk);
                acc = cfg_ready;
                t++;
                @(posedge prog_clk); #1;
            end
            if (!acc) chk("cfg_accept_timeout", 32'd0, 32'd1);
        end
        cfg_valid = 1'b0;
    endtask

    task automatic rb_drive(input int mode);
        int t;
        case (mode)
            1: begin
                while (!load_over) begin
                    @(posedge prog_clk); #1;
                    rb_ready = ($urandom_range(0, 3) != 0);
                end
                rb_ready = 1'b1;
            end
            2: begin
                rb_ready = 1'b0;
                t = 0;
                @(negedge prog_clk);
                while (!rb_valid && t < 200) begin
                    @(negedge prog_clk);
                    t++;
                end
                if (!rb_valid) chk("rb_valid_timeout", 32'd0, 32'd1);
                for (int n = 0; n < 4; n++) begin
                    if (n > 0) @(negedge prog_clk);
                    chk("hold_en_low", 32'(prog_clk_en), 32'd0);
                    chk("hold_bit_count", 32'(bit_count), 32'd4);
                end
                @(posedge prog_clk); #1;
                rb_ready = 1'b1;
            end
            3: begin
                rb_ready = 1'b1;
                t = 0;
                @(negedge prog_clk);
                while (bit_count != CW'(3) && t < 200) begin
                    @(negedge prog_clk);
                    t++;
                end
                @(posedge prog_clk); #1; start = 1'b1;
                @(posedge prog_clk); #1; start = 1'b0;
                @(negedge prog_clk);
                chk("start_in_load_count", 32'(bit_count), 32'd5);
                chk("start_in_load_busy", 32'(busy), 32'd1);
                t = 0;
                while (bit_count != CW'(CL - 1) && t < 200) begin
                    @(negedge prog_clk);
                    t++;
                end
                @(posedge prog_clk); #1; rb_ready = 1'b0; start = 1'b1;
                @(posedge prog_clk); #1; start = 1'b0;
                @(negedge prog_clk);
                chk("start_in_drain_count", 32'(bit_count), 32'(CL));
                chk("start_in_drain_busy", 32'(busy), 32'd1);
                chk("start_in_drain_done", 32'(done), 32'd0);
                chk("drain_rb_valid", 32'(rb_valid), 32'd1);
                @(posedge prog_clk); #1; rb_ready = 1'b1;
            end
            default: rb_ready = 1'b1;
        endcase
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 1000) begin
            @(negedge prog_clk);
            t++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
        load_over = 1'b1;
    endtask

    task automatic run_load(input logic [WW-1:0] w [NW], input int g [NW],
                            input int rb_mode, input int exp_bub);
        logic [CL-1:0] exp_chain;
        logic [WW-1:0] word;
        int idx;
        load_id++;
        load_over = 1'b0;
        if (prev_done) begin
            repeat (2) @(negedge prog_clk);
            chk("done_held", 32'(done), 32'd1);
            chk("done_en_low", 32'(prog_clk_en), 32'd0);
            chk("done_ready_low", 32'(cfg_ready), 32'd0);
            chk("done_busy_low", 32'(busy), 32'd0);
        end
        // Bitstream goes in LSB first; the old chain comes out tail first.
        for (int i = 0; i < CL; i++) begin
            head_q.push_back(w[i / WW][i % WW]);
            exp_chain[CL-1-i] = w[i / WW][i % WW];
        end
        for (int k = 0; k < NRB; k++) begin
            word = '0;
            for (int j = 0; j < WW; j++) begin
                idx = k * WW + j;
                if (idx < CL) word[j] = chain[CL-1-idx];
            end
            rb_q.push_back(word);
        end
        @(posedge prog_clk); #1; start = 1'b1;
        @(posedge prog_clk); #1; start = 1'b0;
        @(negedge prog_clk);
        chk("start_done_clear", 32'(done), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_bit_count", 32'(bit_count), 32'd0);
        fork
            cfg_drive(w, g);
            rb_drive(rb_mode);
            wait_done();
        join
        @(negedge prog_clk);
        chk("head_q_empty", 32'(head_q.size()), 32'd0);
        chk("rb_q_empty", 32'(rb_q.size()), 32'd0);
        chk("end_bit_count", 32'(bit_count), 32'(CL));
        chk("end_done", 32'(done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_en", 32'(prog_clk_en), 32'd0);
        chk("end_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("shift_total", 32'(nshift), 32'(CL));
        chk("chain_contents", 32'(chain), 32'(exp_chain));
        if (exp_bub >= 0) chk("en_bubbles", 32'(last_cyc - first_cyc + 1 - CL), 32'(exp_bub));
        head_q.delete();
        rb_q.delete();
        prev_done = 1'b1;
    endtask

    function automatic logic [31:0] pack_head();
        logic [31:0] v = '0;
        for (int i = 0; i < head_log.size() && i < 32; i++) v[i] = head_log[i];
        return v;
    endfunction

    function automatic logic [31:0] pack_rb();
        logic [31:0] v = '0;
        for (int k = 0; k < rb_log.size() && k < 8; k++) v = v | (32'(rb_log[k]) << (k * WW));
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [WW-1:0] wv [NW];
        int            gv [NW];
        int            t;

        pReset_n = 1'b0; start = 1'b0; cfg_data = '0; cfg_valid = 1'b0; rb_ready = 1'b1;
        repeat (3) @(posedge prog_clk);
        @(negedge prog_clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bit_count", 32'(bit_count), 32'd0);
        chk("rst_en", 32'(prog_clk_en), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("rst_rb_valid", 32'(rb_valid), 32'd0);
        chk("rst_rb_data", 32'(rb_data), 32'd0);
        chk("rst_head", 32'(ccff_head), 32'd0);
        @(posedge prog_clk); #1; pReset_n = 1'b1;
        @(negedge prog_clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // Reset in the middle of a load
        @(posedge prog_clk); #1; start = 1'b1;
        @(posedge prog_clk); #1; start = 1'b0; cfg_data = 4'hF; cfg_valid = 1'b1;
        t = 0;
        @(negedge prog_clk);
        while (bit_count != CW'(4) && t < 100) begin
            @(negedge prog_clk);
            t++;
        end
        chk("midrst_reached", 32'(bit_count), 32'd4);
        @(posedge prog_clk); #3;
        pReset_n = 1'b0;
        #1;
        chk("midrst_en_async", 32'(prog_clk_en), 32'd0);
        chk("midrst_ready_async", 32'(cfg_ready), 32'd0);
        chk("midrst_busy_async", 32'(busy), 32'd0);
        cfg_valid = 1'b0;
        repeat (2) @(posedge prog_clk);
        @(negedge prog_clk); pReset_n = 1'b1;
        @(negedge prog_clk);
        chk("postrst_busy", 32'(busy), 32'd0);
        chk("postrst_done", 32'(done), 32'd0);
        chk("postrst_bit_count", 32'(bit_count), 32'd0);
        chk("postrst_en", 32'(prog_clk_en), 32'd0);
        mon_on = 1'b1;

        // Known previous configuration: tail emits 1,1,0,0,1,0,1,0,0,1
        @(posedge prog_clk); #1; preload_val = 10'b1100101001; preload_req = 1'b1;
        @(posedge prog_clk); #1; preload_req = 1'b0;

        wv = '{4'h5, 4'hA, 4'h3};
        gv = '{0, 0, 0};
        run_load(wv, gv, 0, 0);
        chk("t1_head_seq", pack_head(), 32'h3A5);
        chk("t1_rb_words", pack_rb(), 32'h253);
        chk("t1_rb_count", 32'(rb_log.size()), 32'd3);

        gv = '{0, 3, 0};
        run_load(wv, gv, 0, 3);
        chk("t2_head_seq", pack_head(), 32'h3A5);

        gv = '{0, 0, 0};
        run_load(wv, gv, 2, 4);
        chk("t3_head_seq", pack_head(), 32'h3A5);

        run_load(wv, gv, 3, 0);
        chk("t4_head_seq", pack_head(), 32'h3A5);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NW; i++) begin
                wv[i] = WW'($urandom);
                gv[i] = int'($urandom_range(0, 2));
            end
            run_load(wv, gv, 1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Configuration-chain controller for the routing fabric: streams a bitstream from a word-wide valid/ready source into the serial ccff_head of a chain of switch-block/connection-block mux memories.
- Generates the shift enable consumed by the fabric's prog_clk gate, so the chain advances only on valid bits.
- Returns the displaced previous configuration (from ccff_tail) as readback words.
- Sits between the bitstream source (SPI/host) and the first tile's ccff_head.

Parameters:
- CHAIN_LEN, 64: total configuration bits in the chain (must be >= 1).
- WORD_W, 8: width of bitstream and readback words (must be >= 2).
- CNT_W, $clog2(CHAIN_LEN+1): width of bit_count.

Ports:
- prog_clk  input  1  configuration clock; all state on rising edge.
- pReset_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a load.
- cfg_data  input  WORD_W  bitstream word; bit 0 is shifted first.
- cfg_valid  input  1  cfg_data valid.
- cfg_ready  output  1  word accepted when cfg_valid && cfg_ready.
- ccff_head  output  1  serial bit driven into the chain head.
- ccff_tail  input  1  serial bit returned from the chain tail.
- prog_clk_en  output  1  chain shifts on the prog_clk edge that closes a cycle where this is 1.
- rb_data  output  WORD_W  readback word; bit 0 is the first tail bit captured.
- rb_valid  output  1  rb_data valid.
- rb_ready  input  1  readback accepted when rb_valid && rb_ready.
- busy  output  1  high in LOAD or DRAIN.
- done  output  1  high in DONE; held until the next accepted start.
- bit_count  output  CNT_W  bits shifted so far in the current load.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - State IDLE; all outputs 0; bit_count = 0.
  - Word buffer and readback buffer cleared.
  - prog_clk_en falls immediately.
- States: IDLE, LOAD, DRAIN, DONE.
  - IDLE/DONE + start -> LOAD: bit_count = 0, buffers cleared, done = 0.
  - start in LOAD/DRAIN is ignored.
- Word buffer (sreg, bits_left):
  - cfg_ready = LOAD && (bits_left == 0 || (bits_left == 1 && shift)). Back-to-back words therefore stream with no bubble.
  - On accept: sreg = cfg_data and bits_left = WORD_W. If the final bit of the previous word shifts in the same cycle, it completes first.
- Shift condition: shift = LOAD && bits_left > 0 && !(rb_valid && !rb_ready).
  - prog_clk_en = shift, combinational from registers and rb_ready only.
  - ccff_head = sreg[0] when bits_left > 0, else 0.
- On a shift edge:
  - sreg shifts right; bits_left and bit_count decrement/increment respectively.
  - The ccff_tail value present during the cycle is captured into the readback buffer at bit position rb_cnt.
- Readback:
  - rb_valid rises the cycle after WORD_W bits are captured, or after the final chain bit. A partial final word is zero-padded in the upper bits.
  - rb_valid holds, with rb_data stable, until accepted.
  - A capture completing in the same cycle as rb acceptance is legal; the new word appears the next cycle.
- No input word (bits_left == 0, cfg_valid low): stall with prog_clk_en = 0, no state change.
- Completion, on the shift edge where bit_count reaches CHAIN_LEN:
  - LOAD -> DRAIN.
  - Unshifted bits left in sreg are discarded (bits_left = 0).
  - cfg_ready = 0 from then on.
- DRAIN -> DONE on the cycle the final rb word is accepted.
- DONE: busy = 0, done = 1, prog_clk_en = 0, cfg_ready = 0.
- Reset mid-load: the chain holds a partial configuration. Fabric contents are undefined until a full reload. No recovery is attempted by this block.
- Total shifts per load: exactly CHAIN_LEN, never more.

Test Plan (CHAIN_LEN=10, WORD_W=4 unless stated):
- Reset mid-LOAD after 5 shifts: prog_clk_en = 0 and cfg_ready = 0 asynchronously. After release: IDLE, bit_count = 0, done = 0.
- start; words 0x5, 0xA, 0x3 with cfg_valid always high and rb_ready = 1 -> ccff_head sequence 1,0,1,0,0,1,0,1,1,1; prog_clk_en high for exactly 10 consecutive cycles; upper 2 bits of 0x3 discarded.
- Chain model preloaded with a known pattern whose ccff_tail emits 1,1,0,0,1,0,1,0,0,1 during the load -> rb words 0x3, 0x5, 0x2 (last zero-padded); done rises after the 3rd rb accept.
- cfg_valid deasserted 3 cycles mid-word 2 -> prog_clk_en low exactly those cycles; bit order unchanged.
- rb_ready held low 4 cycles after first rb_valid -> prog_clk_en low; rb_data stable; bit_count frozen at 4; resumes when rb_ready rises.
- start pulsed during LOAD and during DRAIN -> ignored, bit_count unaffected. start in DONE -> new load, done clears next cycle.
